// File: rtl/barcode_reader_pkg.sv
// Shared definitions for the barcode reader.
//   state_e  : frame-decoder states
//   NUM_BITS : number of data bits carried by one frame
package barcode_reader_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      MEAS      = 3'd1,
      WAIT_FALL = 3'd2,
      DLY       = 3'd3,
      DONE      = 3'd4
   } state_e;

   localparam logic [3:0] NUM_BITS = 4'd8;

endpackage

// File: rtl/bc_sync_edge.sv
// Brings the asynchronous barcode line into the clk domain and flags
// falling edges.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   bc      : raw barcode line (asynchronous, idles high)
//   bc_sync : synchronized line level
//   bc_fall : one-cycle pulse when bc_sync goes 1 -> 0
module bc_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic bc,
   output logic bc_sync,
   output logic bc_fall
);

   logic meta_r;
   logic sync_r;
   logic prev_r;

   // Two-flop synchronizer plus a delayed copy; all reset to the idle-high
   // level so leaving reset never looks like a falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_r <= 1'b1;
         sync_r <= 1'b1;
         prev_r <= 1'b1;
      end else begin
         meta_r <= bc;
         sync_r <= meta_r;
         prev_r <= sync_r;
      end
   end

   assign bc_sync = sync_r;
   assign bc_fall = prev_r & ~sync_r;

endmodule

// File: rtl/barcode_reader.sv
// Decodes a pulse-width barcode frame into an 8-bit station ID.
// A start pulse's low time (T_low) is measured; each following data bit is
// sampled T_low cycles after its falling edge (low = 0, high = 1), MSB first.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   BC         : serial barcode line (asynchronous, idles high)
//   clr_ID_vld : consumer acknowledge, clears ID_vld
//   ID         : last received station ID
//   ID_vld     : set on frame completion, held until acknowledged
//   frm_err    : one-cycle pulse when a frame aborts on timeout
module barcode_reader
   import barcode_reader_pkg::*;
#(
   parameter int CNT_W = 22
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       BC,
   input  logic       clr_ID_vld,
   output logic [7:0] ID,
   output logic       ID_vld,
   output logic       frm_err
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W:0]   WD_ZERO  = {(CNT_W+1){1'b0}};
   localparam logic [CNT_W:0]   WD_ONE   = {{CNT_W{1'b0}}, 1'b1};

   logic             bc_sync_s;
   logic             bc_fall_s;

   state_e           state_r,   state_s;
   logic [CNT_W-1:0] low_cnt_r, low_cnt_s;
   logic [CNT_W-1:0] t_low_r,   t_low_s;
   logic [CNT_W-1:0] dly_cnt_r, dly_cnt_s;
   logic [CNT_W:0]   wd_cnt_r,  wd_cnt_s;
   logic [3:0]       bit_cnt_r, bit_cnt_s;
   logic [7:0]       shift_r,   shift_s;
   logic [7:0]       id_r,      id_s;
   logic             id_vld_r,  id_vld_s;
   logic             frm_err_r, frm_err_s;

   bc_sync_edge u_sync (
      .clk     (clk),
      .rst     (rst),
      .bc      (BC),
      .bc_sync (bc_sync_s),
      .bc_fall (bc_fall_s)
   );

   // Next-state and datapath decisions for the frame decoder.
   always_comb begin
      state_s   = state_r;
      low_cnt_s = low_cnt_r;
      t_low_s   = t_low_r;
      dly_cnt_s = dly_cnt_r;
      wd_cnt_s  = wd_cnt_r;
      bit_cnt_s = bit_cnt_r;
      shift_s   = shift_r;
      id_s      = id_r;
      frm_err_s = 1'b0;
      // Acknowledge clears the flag unless DONE sets it below (set wins).
      if (clr_ID_vld) begin
         id_vld_s = 1'b0;
      end else begin
         id_vld_s = id_vld_r;
      end

      case (state_r)
         IDLE: begin
            if (bc_fall_s) begin
               low_cnt_s = CNT_ZERO;
               state_s   = MEAS;
            end else begin
               state_s   = IDLE;
            end
         end
         MEAS: begin
            if (bc_sync_s) begin
               t_low_s   = low_cnt_r;
               bit_cnt_s = 4'd0;
               wd_cnt_s  = WD_ZERO;
               state_s   = WAIT_FALL;
            end else if (low_cnt_r == CNT_MAX) begin
               // Start pulse too long to measure: abandon the frame.
               frm_err_s = 1'b1;
               state_s   = IDLE;
            end else begin
               low_cnt_s = low_cnt_r + CNT_ONE;
            end
         end
         WAIT_FALL: begin
            if (bc_fall_s) begin
               dly_cnt_s = t_low_r;
               state_s   = DLY;
            end else if (wd_cnt_r >= {t_low_r, 1'b0}) begin
               // No bit edge within two start-pulse widths: line went dead.
               frm_err_s = 1'b1;
               state_s   = IDLE;
            end else begin
               wd_cnt_s  = wd_cnt_r + WD_ONE;
            end
         end
         DLY: begin
            // Loaded one cycle after the edge, so sampling at zero lands
            // T_low + 1 cycles after the edge, i.e. the measured pulse width.
            if (dly_cnt_r == CNT_ZERO) begin
               shift_s   = {shift_r[6:0], bc_sync_s};
               bit_cnt_s = bit_cnt_r + 4'd1;
               wd_cnt_s  = WD_ZERO;
               if ((bit_cnt_r + 4'd1) < NUM_BITS) begin
                  state_s = WAIT_FALL;
               end else begin
                  state_s = DONE;
               end
            end else begin
               dly_cnt_s = dly_cnt_r - CNT_ONE;
            end
         end
         DONE: begin
            id_s     = shift_r;
            id_vld_s = 1'b1;
            state_s  = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         low_cnt_r <= CNT_ZERO;
         t_low_r   <= CNT_ZERO;
         dly_cnt_r <= CNT_ZERO;
         wd_cnt_r  <= WD_ZERO;
         bit_cnt_r <= 4'd0;
         shift_r   <= 8'h00;
         id_r      <= 8'h00;
         id_vld_r  <= 1'b0;
         frm_err_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         low_cnt_r <= low_cnt_s;
         t_low_r   <= t_low_s;
         dly_cnt_r <= dly_cnt_s;
         wd_cnt_r  <= wd_cnt_s;
         bit_cnt_r <= bit_cnt_s;
         shift_r   <= shift_s;
         id_r      <= id_s;
         id_vld_r  <= id_vld_s;
         frm_err_r <= frm_err_s;
      end
   end

   assign ID      = id_r;
   assign ID_vld  = id_vld_r;
   assign frm_err = frm_err_r;

endmodule

// File: tb/tb_barcode_reader.sv
// Self-checking bench for barcode_reader: frames are generated from their
// bit-level description (period, ID) and the expected ID / ID_vld come from
// a frame-level model of what the consumer should see.
module tb_barcode_reader;
   import barcode_reader_pkg::*;

   localparam int CNT_W = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       bc;
   logic       clr_id_vld;
   logic [7:0] id;
   logic       id_vld;
   logic       frm_err;

   int         checks = 0;
   int         errors = 0;
   int         err_pulses = 0;

   logic [7:0] exp_id;
   logic       exp_vld;

   always #10 clk = ~clk;

   barcode_reader #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .BC         (bc),
      .clr_ID_vld (clr_id_vld),
      .ID         (id),
      .ID_vld     (id_vld),
      .frm_err    (frm_err)
   );

   // Count frame-error pulses seen by the consumer.
   always @(negedge clk) begin
      if (frm_err === 1'b1) err_pulses++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Start pulse low for half a period, then nbits data bits MSB first:
   // '1' low for a quarter period, '0' low for three quarters.
   task automatic send_frame(input int p, input logic [7:0] v, input int nbits);
      int lo;
      bc = 1'b0; idle(p / 2);
      bc = 1'b1; idle(p - p / 2);
      for (int i = 7; i > 7 - nbits; i--) begin
         lo = v[i] ? p / 4 : (3 * p) / 4;
         bc = 1'b0; idle(lo);
         bc = 1'b1; idle(p - lo);
      end
   endtask

   task automatic pulse_clr();
      clr_id_vld = 1'b1; idle(1); clr_id_vld = 1'b0;
      exp_vld = 1'b0;
   endtask

   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20000 && !seen; i++) begin
         @(negedge clk);
         if (dut.state_r == DONE) seen = 1'b1;
      end
   endtask

   task automatic full_frame(input string tag, input int p, input logic [7:0] v);
      send_frame(p, v, 8);
      exp_id = v; exp_vld = 1'b1;
      idle(10);
      check({tag, "_id"}, id, exp_id);
      check({tag, "_vld"}, id_vld, exp_vld);
   endtask

   initial begin
      int         p;
      int         e0;
      logic [7:0] v;
      bit         seen;

      rst = 1'b1; bc = 1'b1; clr_id_vld = 1'b0;
      idle(3);
      rst = 1'b0;
      exp_id = 8'h00; exp_vld = 1'b0;
      idle(1);
      check("rst_id", id, exp_id);
      check("rst_vld", id_vld, exp_vld);
      check("rst_err", frm_err, 1'b0);
      idle(20);

      // Basic decode and overwrite while still valid.
      full_frame("f01", 256, 8'h01);
      idle(40);
      full_frame("fA5", 256, 8'hA5);
      idle(40);
      full_frame("f3C", 256, 8'h3C);
      idle(40);

      // Acknowledge in the same cycle as completion: set wins.
      pulse_clr();
      check("clr_vld", id_vld, exp_vld);
      fork
         send_frame(256, 8'h5A, 8);
         begin
            wait_done(seen);
            clr_id_vld = 1'b1; idle(1); clr_id_vld = 1'b0;
         end
      join
      check("coinc_seen", seen, 1'b1);
      exp_id = 8'h5A; exp_vld = 1'b1;
      idle(10);
      check("coinc_id", id, exp_id);
      check("coinc_vld", id_vld, exp_vld);
      idle(40);

      // Acknowledge one cycle after completion: cleared.
      fork
         send_frame(256, 8'hC3, 8);
         begin
            wait_done(seen);
            idle(1);
            clr_id_vld = 1'b1; idle(1); clr_id_vld = 1'b0;
         end
      join
      check("late_seen", seen, 1'b1);
      exp_id = 8'hC3; exp_vld = 1'b0;
      idle(10);
      check("late_id", id, exp_id);
      check("late_vld", id_vld, exp_vld);
      idle(40);

      // Start pulse then silence: watchdog abort.
      e0 = err_pulses;
      bc = 1'b0; idle(128);
      bc = 1'b1; idle(3 * 128 + 10);
      check("wd_err", err_pulses - e0, 1);
      check("wd_id", id, exp_id);
      check("wd_vld", id_vld, exp_vld);

      // Start pulse longer than the low counter can hold.
      e0 = err_pulses;
      bc = 1'b0; idle(1100);
      bc = 1'b1; idle(20);
      check("sat_err", err_pulses - e0, 1);
      check("sat_id", id, exp_id);

      // Reset mid-frame, then a clean frame.
      full_frame("pre", 128, 8'h99);
      idle(40);
      e0 = err_pulses;
      send_frame(128, 8'hFF, 4);
      bc = 1'b1; rst = 1'b1; idle(1); rst = 1'b0;
      exp_id = 8'h00; exp_vld = 1'b0;
      idle(300);
      check("mid_rst_id", id, exp_id);
      check("mid_rst_vld", id_vld, exp_vld);
      check("mid_rst_err", err_pulses - e0, 0);
      full_frame("f02", 128, 8'h02);
      idle(40);

      // Short and long periods back to back.
      full_frame("p40", 64, 8'h80);
      idle(40);
      full_frame("p200", 512, 8'h7F);
      idle(40);

      // Randomized frames with random acknowledges.
      for (int k = 0; k < 6; k++) begin
         p = $urandom_range(48, 200);
         v = 8'($urandom);
         full_frame("rnd", p, v);
         if ($urandom_range(0, 1) == 1) begin
            pulse_clr();
            idle(1);
            check("rnd_clr", id_vld, exp_vld);
            check("rnd_clr_id", id, exp_id);
         end
         idle($urandom_range(5, 60));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
